barrel_rotr_pipe_32: RTL
========================

// Module: barrel_rotr_pipe_32
// PURPOSE
//  Pipelined right-direction companion to the left-rotate barrel shifter. Performs ROR, SRL, SRA
//  and ROL-by-complement on a DATA_W word through a 2-stage registered datapath.
//  Uses a valid/ready handshake on both sides with full backpressure.
//  Sits between the operand issue logic and the ALU result mux. Carries an opaque tag for reordering checks.
// PARAMETERS
//  DATA_W   32  datapath width; power of two, >= 16
//  SHAMT_W  5   shift-amount width, = log2(DATA_W); derived, do not override
//  TAG_W    4   width of the opaque tag carried alongside data
// PORTS
//  clk        in   1        single clock, rising edge
//  rst_n      in   1        asynchronous active-low reset
//  in_valid   in   1        request valid
//  in_ready   out  1        request accepted when in_valid & in_ready
//  in_data    in   DATA_W   operand
//  in_shamt   in   SHAMT_W  shift amount, 0..DATA_W-1
//  in_op      in   2        00 ROR, 01 SRL, 10 SRA, 11 ROL
//  in_tag     in   TAG_W    passthrough tag
//  out_valid  out  1        result valid
//  out_ready  in   1        consumer ready; transfer when out_valid & out_ready
//  out_data   out  DATA_W   result
//  out_tag    out  TAG_W    tag of the request that produced out_data
// BEHAVIOUR
//  - Reset (async assert, sync release): s1_valid=0, out_valid=0, out_data=0, out_tag=0; in_ready=1 while empty.
//  - Input conditioning (comb, before S1 reg):
//    - ROL: amt = (DATA_W - shamt) mod DATA_W. Other ops: amt = shamt.
//    - fill = in_data[DATA_W-1] for SRA, else 0.
//    - mask_n = shamt.
//  - S1 register: holds data rotated right by amt[2:0], plus amt[SHAMT_W-1:3], op, fill, mask_n, tag.
//  - S2 / output register: completes the rotation by amt[SHAMT_W-1:3]*8 (8,16,...).
//    - For SRL/SRA, the top mask_n bits are replaced with fill. ROR/ROL are unmasked.
//  - Latency: exactly 2 cycles from accept to out_valid when there is no backpressure.
//  - Throughput: 1 result per cycle.
//  - Advance rules:
//    - s2_adv = !out_valid | out_ready
//    - s1_adv = !s1_valid | s2_adv
//    - in_ready = s1_adv (combinational; no dependency on in_valid)
//  - Stall: when out_valid & !out_ready, out_data and out_tag hold stable. S1 holds if it is full.
//    At most 2 requests are buffered. Order is strictly preserved.
//  - Simultaneous accept and emit in the same cycle: both occur, with no bubble inserted.
//  - shamt=0: output equals input for all ops, including ROL (amt wraps to 0).
//  - shamt=DATA_W-1: SRL of the MSB gives 1; SRA of a negative value gives all ones.
//  - Reset mid-operation flushes both stages. In-flight requests are dropped without response.
//  - in_data/shamt/op/tag are sampled only on accept. Their values are don't-care otherwise.
// STRUCTURE
//  - Shared package barrel_pkg:
//    - op encodings OP_ROR/OP_SRL/OP_SRA/OP_ROL (2-bit)
//    - default DATA_W, and a function for the low-bit right-fill mask.
//  - One natural sub-module: rotr_stage
//    - combinational right rotate by (sel * STEP), with STEP and SEL_W as parameters.
//    - Instantiated once per stage: STEP=1 (3 levels) and STEP=8 (SHAMT_W-3 levels).
//  - Handshake/valid logic stays in the top module. No FSM beyond the two valid bits.
// TESTING
//  1. ROR 0x12345678 amt 4 -> 0x81234567 two cycles after accept; tag 0x3 returned unchanged.
//  2. SRL 0x80000000 amt 31 -> 0x00000001; SRA 0x80000000 amt 4 -> 0xF8000000.
//  3. ROL 0x12345678 amt 8 -> 0x34567812; ROL amt 0 -> 0x12345678 (wrap check).
//  4. Back-to-back 3 requests, out_ready held low 5 cycles:
//     - in_ready drops after 2 accepts
//     - out_data stable during the stall
//     - after release, results emerge in order, tags 0,1,2, none lost or duplicated.
//  5. Random op/shamt/data, 10k transactions with random in_valid/out_ready:
//     results match a reference model; no tag gaps.
//  6. Assert rst_n with both stages full:
//     - out_valid=0 and out_data=0 immediately, asynchronously
//     - after release, first new request appears at latency 2.

Source files
------------

// File: rtl/barrel_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : barrel_pkg
//  Description : Shared definitions for the right-direction barrel shifter:
//                operation encodings, default datapath width and the helper
//                that builds the keep/fill mask for logical/arithmetic shifts.
//  Revision    : 1.0 - initial release
// ============================================================================
package barrel_pkg;

  localparam int DEFAULT_DATA_W = 32;

  typedef enum logic [1:0] {
    OP_ROR = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROL = 2'b11
  } op_e;

  // One bit of the low-bit keep mask for a right shift by n on a word of
  // 'width' bits: bit 'pos' keeps rotated data when it lies below the n
  // vacated top positions, otherwise it takes the fill value.
  function automatic logic keep_bit(input int unsigned pos,
                                    input int unsigned width,
                                    input int unsigned n);
    keep_bit = ((pos + n) < width);
  endfunction

endpackage : barrel_pkg
`default_nettype wire

// File: rtl/rotr_stage.sv
`default_nettype none
// ============================================================================
//  Module      : rotr_stage
//  Description : Combinational right rotate of din by (sel * STEP) positions,
//                built as SEL_W log-levels; level k rotates by STEP << k.
//  Ports       : din  [DATA_W-1:0]  word to rotate
//                sel  [SEL_W-1:0]   rotate amount in units of STEP
//                dout [DATA_W-1:0]  rotated word
//  Revision    : 1.0 - initial release
// ============================================================================
module rotr_stage #(
  parameter int DATA_W = 32,
  parameter int STEP   = 1,
  parameter int SEL_W  = 3
) (
  input  logic [DATA_W-1:0] din,
  input  logic [SEL_W-1:0]  sel,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] w_lvl [SEL_W+1];

  assign w_lvl[0] = din;

  for (genvar k = 0; k < SEL_W; k++) begin : g_level
    localparam int c_rot = (STEP << k) % DATA_W;
    // A zero rotation degenerates cleanly: the left shift by DATA_W is zero.
    assign w_lvl[k+1] = sel[k]
                        ? ((w_lvl[k] >> c_rot) | (w_lvl[k] << (DATA_W - c_rot)))
                        : w_lvl[k];
  end

  assign dout = w_lvl[SEL_W];

endmodule : rotr_stage
`default_nettype wire

// File: rtl/barrel_rotr_pipe_32.sv
`default_nettype none
// ============================================================================
//  Module      : barrel_rotr_pipe_32
//  Description : Two-stage pipelined right barrel shifter (ROR, SRL, SRA and
//                ROL-by-complement) with valid/ready handshakes and full
//                backpressure. Carries an opaque tag alongside each request.
//  Ports       : clk, rst_n                 clock, async active-low reset
//                in_valid/in_ready          request handshake
//                in_data/in_shamt/in_op/in_tag  request payload
//                out_valid/out_ready        result handshake
//                out_data/out_tag           result payload
//  Revision    : 1.0 - initial release
// ============================================================================
module barrel_rotr_pipe_32
  import barrel_pkg::*;
#(
  parameter  int DATA_W  = DEFAULT_DATA_W,
  parameter  int TAG_W   = 4,
  localparam int SHAMT_W = $clog2(DATA_W)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_op,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [TAG_W-1:0]   out_tag
);

  // Upper rotate bits handled by the byte-granular second stage.
  localparam int c_hi_w = SHAMT_W - 3;

  // --------------------------------------------------------------------------
  // Input conditioning
  // --------------------------------------------------------------------------
  logic [SHAMT_W-1:0] w_amt;
  logic               w_fill;
  logic [DATA_W-1:0]  w_s1_rot;

  always_comb begin
    // ROL by n equals ROR by (DATA_W - n) mod DATA_W; the modulo is the
    // natural wrap of SHAMT_W-bit subtraction, so shamt=0 stays 0.
    w_amt  = (in_op == OP_ROL) ? ({SHAMT_W{1'b0}} - in_shamt) : in_shamt;
    w_fill = (in_op == OP_SRA) & in_data[DATA_W-1];
  end

  rotr_stage #(
    .DATA_W (DATA_W),
    .STEP   (1),
    .SEL_W  (3)
  ) u_rot_fine (
    .din  (in_data),
    .sel  (w_amt[2:0]),
    .dout (w_s1_rot)
  );

  // --------------------------------------------------------------------------
  // Handshake / advance
  // --------------------------------------------------------------------------
  logic r_s1_valid;
  logic r_out_valid;
  logic w_s2_adv;
  logic w_s1_adv;

  assign w_s2_adv = !r_out_valid | out_ready;
  assign w_s1_adv = !r_s1_valid | w_s2_adv;
  assign in_ready = w_s1_adv;

  // --------------------------------------------------------------------------
  // Stage 1 register
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0]  r_s1_data;
  logic [c_hi_w-1:0]  r_s1_hi;
  logic [1:0]         r_s1_op;
  logic               r_s1_fill;
  logic [SHAMT_W-1:0] r_s1_mask_n;
  logic [TAG_W-1:0]   r_s1_tag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_data   <= '0;
      r_s1_hi     <= '0;
      r_s1_op     <= '0;
      r_s1_fill   <= 1'b0;
      r_s1_mask_n <= '0;
      r_s1_tag    <= '0;
    end else if (w_s1_adv) begin
      r_s1_valid <= in_valid;
      // Payload is only captured on accept so idle inputs never toggle it.
      if (in_valid) begin
        r_s1_data   <= w_s1_rot;
        r_s1_hi     <= w_amt[SHAMT_W-1:3];
        r_s1_op     <= in_op;
        r_s1_fill   <= w_fill;
        r_s1_mask_n <= in_shamt;
        r_s1_tag    <= in_tag;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2: coarse rotate and shift masking
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] w_s2_rot;
  logic [DATA_W-1:0] w_keep;
  logic [DATA_W-1:0] w_s2_res;

  rotr_stage #(
    .DATA_W (DATA_W),
    .STEP   (8),
    .SEL_W  (c_hi_w)
  ) u_rot_coarse (
    .din  (r_s1_data),
    .sel  (r_s1_hi),
    .dout (w_s2_rot)
  );

  always_comb begin
    w_keep = '0;
    for (int i = 0; i < DATA_W; i++) begin
      w_keep[i] = keep_bit(i, DATA_W, int'(r_s1_mask_n));
    end
  end

  always_comb begin
    w_s2_res = w_s2_rot;
    // Shifts reuse the rotator: the wrapped-around top bits are overwritten
    // with the fill value (zero for SRL, sign for SRA).
    if ((r_s1_op == OP_SRL) || (r_s1_op == OP_SRA)) begin
      w_s2_res = (w_s2_rot & w_keep) | ({DATA_W{r_s1_fill}} & ~w_keep);
    end
  end

  // --------------------------------------------------------------------------
  // Output register
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] r_out_data;
  logic [TAG_W-1:0]  r_out_tag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_tag   <= '0;
    end else if (w_s2_adv) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_data <= w_s2_res;
        r_out_tag  <= r_s1_tag;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_tag   = r_out_tag;

endmodule : barrel_rotr_pipe_32
`default_nettype wire
